// File: rtl/cpu_pio_key_in.sv
// Avalon-MM input PIO: synchronises, debounces and edge-captures board inputs,
// with a maskable level IRQ and registered read data (latency 1).

module cpu_pio_key_in_lane #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_i,
  output logic stable_o
);
  logic stable_q;

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stable_q <= 1'b0;
        else          stable_q <= sync_i;
      end
    end else begin : g_deb
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      logic [CW-1:0] cnt_q;

      // Counter only runs while sync disagrees with stable; any agreement restarts it.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stable_q <= 1'b0;
          cnt_q    <= '0;
        end else if (sync_i == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_q <= sync_i;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  endgenerate

  assign stable_o = stable_q;
endmodule

module cpu_pio_key_in #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_w, stable_d_q;
  logic [WIDTH-1:0] rise_w, fall_w, edge_w;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] ecap_q, ecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q;
  logic             wr_en;
  logic             unused_wd;

  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      cpu_pio_key_in_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
        .clk      (clk),
        .reset_n  (reset_n),
        .sync_i   (sync2_q[i]),
        .stable_o (stable_w[i])
      );
    end
  endgenerate

  assign rise_w = stable_w & ~stable_d_q;
  assign fall_w = ~stable_w & stable_d_q;
  assign edge_w = (EDGE_TYPE == 0) ? rise_w :
                  (EDGE_TYPE == 1) ? fall_w : (rise_w | fall_w);

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    irqmask_d = irqmask_q;
    ecap_d    = ecap_q;
    if (wr_en && address == 2'd1) irqmask_d = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd3) ecap_d = ecap_q & ~writedata[WIDTH-1:0];
    // Set after clear so an edge landing on a clearing write is never lost.
    ecap_d = ecap_d | edge_w;
  end

  always_comb begin
    readdata_d = '0;
    if (chipselect) begin
      case (address)
        2'd0:    readdata_d = 32'(stable_w);
        2'd1:    readdata_d = 32'(irqmask_q);
        2'd3:    readdata_d = 32'(ecap_q);
        default: readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d_q <= '0;
      irqmask_q  <= '0;
      ecap_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      stable_d_q <= stable_w;
      irqmask_q  <= irqmask_d;
      ecap_q     <= ecap_d;
      readdata_q <= readdata_d;
      irq_q      <= |(ecap_q & irqmask_q);
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_cpu_pio_key_in.sv
// Bench for cpu_pio_key_in: reads scored through a queue, register vectors from a table,
// hand-timed sequences for debounce, IRQ timing, edge/clear collision and reset.

module tb_cpu_pio_key_in;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  cpu_pio_key_in #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] exp; int tag; } sb_t;
  typedef struct { bit wr; logic [1:0] addr; logic [31:0] data; } vec_t;

  sb_t  sb_q[$];
  int   rd_tag = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic rd_issued = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    sb_q.push_back('{e, rd_tag});
    rd_tag++;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Read data must appear exactly one cycle after the read was sampled.
  always @(posedge clk) rd_issued <= chipselect & write_n;

  always @(negedge clk) begin
    if (rd_issued) begin
      if (sb_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rd_unexpected: got %h expected no read", readdata);
      end else begin
        sb_t s;
        s = sb_q.pop_front();
        chk($sformatf("rd#%0d", s.tag), readdata, s.exp);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[16];
    tbl[0]  = '{1'b0, 2'd2, 32'h0000_0000};
    tbl[1]  = '{1'b1, 2'd1, 32'hFFFF_FFFF};
    tbl[2]  = '{1'b0, 2'd1, 32'h0000_000F};
    tbl[3]  = '{1'b1, 2'd1, 32'hFFFF_FFF5};
    tbl[4]  = '{1'b0, 2'd1, 32'h0000_0005};
    tbl[5]  = '{1'b1, 2'd0, 32'h0000_0000};
    tbl[6]  = '{1'b0, 2'd0, 32'h0000_000F};
    tbl[7]  = '{1'b1, 2'd2, 32'hFFFF_FFFF};
    tbl[8]  = '{1'b0, 2'd2, 32'h0000_0000};
    tbl[9]  = '{1'b0, 2'd3, 32'h0000_0008};
    tbl[10] = '{1'b1, 2'd3, 32'h0000_0007};
    tbl[11] = '{1'b0, 2'd3, 32'h0000_0008};
    tbl[12] = '{1'b1, 2'd3, 32'h0000_0008};
    tbl[13] = '{1'b0, 2'd3, 32'h0000_0000};
    tbl[14] = '{1'b1, 2'd1, 32'h0000_0000};
    tbl[15] = '{1'b0, 2'd1, 32'h0000_0000};

    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = '0; in_port = 4'hF;

    // Reset with inputs held high: one rising edge per bit after release.
    repeat (3) tick();
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) rd(2'd0, (k >= 19) ? 32'hF : 32'h0);
    rd(2'd3, 32'hF);
    chk("rst_irq_masked", 32'(irq), 32'h0);
    wr(2'd3, 32'hF);
    rd(2'd3, 32'h0);

    // Falling edges are not captured in rising mode.
    in_port = 4'h0;
    repeat (22) tick();
    rd(2'd0, 32'h0);
    rd(2'd3, 32'h0);

    // Bounce of 10 cycles is rejected.
    in_port = 4'h1;
    for (int k = 1; k <= 30; k++) begin
      if (k == 11) in_port = 4'h0;
      rd(2'd0, 32'h0);
    end

    // Held change is accepted exactly 2+16 cycles later.
    in_port = 4'h1;
    for (int k = 1; k <= 22; k++) rd(2'd0, (k >= 19) ? 32'h1 : 32'h0);
    rd(2'd3, 32'h1);
    wr(2'd3, 32'h1);

    // IRQ raise and clear timing.
    wr(2'd1, 32'h2);
    in_port = 4'h3;
    repeat (19) tick();
    chk("irq_before", 32'(irq), 32'h0);
    tick();
    chk("irq_raised", 32'(irq), 32'h1);
    rd(2'd3, 32'h2);
    wr(2'd3, 32'h2);
    chk("irq_hold", 32'(irq), 32'h1);
    tick();
    chk("irq_cleared", 32'(irq), 32'h0);
    rd(2'd3, 32'h0);

    // Edge and clear on the same cycle: edge wins.
    in_port = 4'h7;
    repeat (18) tick();
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h4);
    chk("collide_irq", 32'(irq), 32'h0);
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h0);

    // Masked edge, then unmask.
    wr(2'd1, 32'h0);
    in_port = 4'hF;
    repeat (22) tick();
    rd(2'd3, 32'h8);
    chk("mask_irq_off", 32'(irq), 32'h0);
    wr(2'd1, 32'h8);
    chk("mask_irq_lag", 32'(irq), 32'h0);
    tick();
    chk("mask_irq_on", 32'(irq), 32'h1);
    rd(2'd1, 32'h8);

    // Register access vectors.
    for (int v = 0; v < 16; v++) begin
      if (tbl[v].wr) wr(tbl[v].addr, tbl[v].data);
      else           rd(tbl[v].addr, tbl[v].data);
    end
    chk("tbl_irq", 32'(irq), 32'h0);
    rd(2'd0, 32'hF);
    tick();
    chk("rd_idle_zero", readdata, 32'h0);

    // Reset mid-debounce with a pending interrupt.
    wr(2'd1, 32'hF);
    in_port = 4'h0;
    repeat (22) tick();
    in_port = 4'h1;
    repeat (21) tick();
    chk("pre_rst_irq", 32'(irq), 32'h1);
    in_port = 4'h0;
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    chk("async_rst_irq", 32'(irq), 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (22) tick();
    rd(2'd0, 32'h0);
    rd(2'd1, 32'h0);
    rd(2'd3, 32'h0);
    chk("post_rst_irq", 32'(irq), 32'h0);

    tick();
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
